// File: rtl/mem_stage.sv
// Memory-access stage between EX and write-back. ALU results pass through in one cycle.
// Loads and stores run a req/ack handshake with a bounded wait, then emit one registered WB bundle.
module mem_stage #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int REG_W   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_ld,
  input  logic              in_st,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [REG_W-1:0]  in_rd,
  input  logic              in_we,
  input  logic              in_hlt,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [REG_W-1:0]  out_rd,
  output logic              out_we,
  output logic              out_hlt,
  output logic              err
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, REQ, HALT} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;

  // p0: request captured from EX, held for the whole memory access
  logic                req_p0, req_d;
  logic                wr_p0, wr_d;
  logic [ADDR_W-1:0]   addr_p0, addr_d;
  logic [DATA_W-1:0]   wdata_p0, wdata_d;
  logic [REG_W-1:0]    rd_p0, rd_d;
  logic                we_p0, we_d;
  logic                hlt_p0, hlt_d;

  // p1: write-back bundle
  logic                vld_p1, vld_d;
  logic [DATA_W-1:0]   data_p1, data_d;
  logic [REG_W-1:0]    rd_p1, rd1_d;
  logic                we_p1, we1_d;
  logic                hlt_p1, hlt1_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    req_d   = req_p0;
    wr_d    = wr_p0;
    addr_d  = addr_p0;
    wdata_d = wdata_p0;
    rd_d    = rd_p0;
    we_d    = we_p0;
    hlt_d   = hlt_p0;
    vld_d   = 1'b0;
    data_d  = data_p1;
    rd1_d   = rd_p1;
    we1_d   = we_p1;
    hlt1_d  = hlt_p1;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (in_ld || in_st) begin
            state_d = REQ;
            cnt_d   = '0;
            req_d   = 1'b1;
            wr_d    = in_st;
            addr_d  = in_addr;
            wdata_d = in_wdata;
            rd_d    = in_rd;
            we_d    = in_we;
            hlt_d   = in_hlt;
          end else begin
            vld_d   = 1'b1;
            data_d  = in_alu;
            rd1_d   = in_rd;
            we1_d   = in_we;
            hlt1_d  = in_hlt;
            if (in_hlt) state_d = HALT;
          end
        end
      end
      REQ: begin
        if (mem_ack) begin
          req_d   = 1'b0;
          vld_d   = 1'b1;
          data_d  = wr_p0 ? '0 : mem_rdata;
          we1_d   = wr_p0 ? 1'b0 : we_p0;
          rd1_d   = rd_p0;
          hlt1_d  = hlt_p0;
          state_d = hlt_p0 ? HALT : IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // Abandon the access: report it to WB without a register write
          req_d   = 1'b0;
          err_d   = 1'b1;
          vld_d   = 1'b1;
          data_d  = '0;
          we1_d   = 1'b0;
          rd1_d   = rd_p0;
          hlt1_d  = hlt_p0;
          state_d = hlt_p0 ? HALT : IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HALT: ;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      req_p0   <= 1'b0;
      wr_p0    <= 1'b0;
      addr_p0  <= '0;
      wdata_p0 <= '0;
      rd_p0    <= '0;
      we_p0    <= 1'b0;
      hlt_p0   <= 1'b0;
      vld_p1   <= 1'b0;
      data_p1  <= '0;
      rd_p1    <= '0;
      we_p1    <= 1'b0;
      hlt_p1   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      req_p0   <= req_d;
      wr_p0    <= wr_d;
      addr_p0  <= addr_d;
      wdata_p0 <= wdata_d;
      rd_p0    <= rd_d;
      we_p0    <= we_d;
      hlt_p0   <= hlt_d;
      vld_p1   <= vld_d;
      data_p1  <= data_d;
      rd_p1    <= rd1_d;
      we_p1    <= we1_d;
      hlt_p1   <= hlt1_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign mem_req   = req_p0;
  assign mem_wr    = wr_p0;
  assign mem_addr  = addr_p0;
  assign mem_wdata = wdata_p0;
  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_rd    = rd_p1;
  assign out_we    = we_p1;
  assign out_hlt   = hlt_p1;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus randomized transactions checked
// against a transaction-level model of the write-back result and error flag.
module tb_mem_stage;
  localparam int DW = 16;
  localparam int AW = 16;
  localparam int RW = 4;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, in_ld, in_st, in_we, in_hlt;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_wdata, in_alu;
  logic [RW-1:0] in_rd;
  logic          mem_req, mem_wr, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          out_valid, out_we, out_hlt, err;
  logic [DW-1:0] out_data;
  logic [RW-1:0] out_rd;

  int   n_checks = 0;
  int   n_err    = 0;
  logic model_err = 1'b0;

  mem_stage #(.DATA_W(DW), .ADDR_W(AW), .REG_W(RW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_ld(in_ld), .in_st(in_st),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_alu(in_alu), .in_rd(in_rd),
    .in_we(in_we), .in_hlt(in_hlt),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_data(out_data), .out_rd(out_rd), .out_we(out_we),
    .out_hlt(out_hlt), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle(input logic ack_noise);
    in_valid  = 1'b0;
    mem_ack   = ack_noise;
    mem_rdata = DW'($urandom);
    step();
    mem_ack = 1'b0;
    chk("idle_out_valid", out_valid, 1'b0);
    chk("idle_mem_req", mem_req, 1'b0);
    chk("idle_in_ready", in_ready, 1'b1);
    chk("idle_err", err, model_err);
  endtask

  task automatic do_alu(input logic [DW-1:0] alu, input logic [RW-1:0] rd,
                        input logic we, input logic hlt);
    chk("alu_ready_pre", in_ready, 1'b1);
    in_valid = 1'b1; in_ld = 1'b0; in_st = 1'b0;
    in_alu = alu; in_rd = rd; in_we = we; in_hlt = hlt;
    in_addr = AW'($urandom); in_wdata = DW'($urandom);
    mem_ack = 1'($urandom_range(0, 1));
    step();
    in_valid = 1'b0; in_hlt = 1'b0; mem_ack = 1'b0;
    chk("alu_out_valid", out_valid, 1'b1);
    chk("alu_out_data", out_data, alu);
    chk("alu_out_rd", out_rd, rd);
    chk("alu_out_we", out_we, we);
    chk("alu_out_hlt", out_hlt, hlt);
    chk("alu_mem_req", mem_req, 1'b0);
    chk("alu_in_ready", in_ready, !hlt);
  endtask

  // lat = index of the request cycle carrying mem_ack; lat >= TO means never acked
  task automatic do_mem(input logic ld, input logic st, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [RW-1:0] rd,
                        input logic we, input logic hlt, input int lat,
                        input logic [DW-1:0] rdata);
    logic acked;
    chk("mem_ready_pre", in_ready, 1'b1);
    in_valid = 1'b1; in_ld = ld; in_st = st; in_addr = addr; in_wdata = wdata;
    in_rd = rd; in_we = we; in_hlt = hlt; in_alu = DW'($urandom);
    step();
    // upstream keeps presenting a bundle while stalled; it must be ignored
    in_ld = 1'b0; in_st = 1'b0; in_hlt = 1'b0; in_alu = DW'($urandom);
    for (int k = 0; k < TO; k++) begin
      chk("req_mem_req", mem_req, 1'b1);
      chk("req_mem_wr", mem_wr, st);
      chk("req_mem_addr", mem_addr, addr);
      chk("req_mem_wdata", mem_wdata, wdata);
      chk("req_in_ready", in_ready, 1'b0);
      chk("req_out_valid", out_valid, 1'b0);
      if (k == lat) begin
        mem_ack = 1'b1; mem_rdata = rdata; in_valid = 1'b0;
        step();
        break;
      end
      if (k == TO - 1) begin
        mem_ack = 1'b0; in_valid = 1'b0;
        step();
        break;
      end
      mem_ack = 1'b0; mem_rdata = DW'($urandom);
      step();
    end
    mem_ack = 1'b0;
    acked = (lat < TO);
    if (!acked) model_err = 1'b1;
    chk("mem_done_req", mem_req, 1'b0);
    chk("mem_out_valid", out_valid, 1'b1);
    if (acked) chk("mem_out_data", out_data, st ? '0 : rdata);
    chk("mem_out_we", out_we, acked && !st && we);
    chk("mem_out_rd", out_rd, rd);
    chk("mem_out_hlt", out_hlt, hlt);
    chk("mem_err", err, model_err);
    chk("mem_in_ready", in_ready, !hlt);
  endtask

  initial begin
    int op, lat;
    logic ld, st;
    rst_n = 1'b1;
    in_valid = 1'b0; in_ld = 1'b0; in_st = 1'b0; in_we = 1'b0; in_hlt = 1'b0;
    in_addr = '0; in_wdata = '0; in_alu = '0; in_rd = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_wr", mem_wr, 1'b0);
    chk("rst_mem_addr", mem_addr, '0);
    chk("rst_out_data", out_data, '0);
    chk("rst_err", err, 1'b0);
    rst_n = 1'b0;
    step();
    chk("rel_in_ready", in_ready, 1'b1);

    // 1: ALU pass-through, back-to-back
    do_alu(16'h1234, 4'd3, 1'b1, 1'b0);
    do_alu(16'h5678, 4'd7, 1'b0, 1'b0);
    idle_cycle(1'b1);

    // 2: load acked in the third request cycle
    do_mem(1'b1, 1'b0, 16'h0040, 16'h0000, 4'd5, 1'b1, 1'b0, 2, 16'hBEEF);
    idle_cycle(1'b0);

    // 3: zero-wait store, next bundle accepted right away
    do_mem(1'b0, 1'b1, 16'h0010, 16'h00AA, 4'd2, 1'b1, 1'b0, 0, 16'hCAFE);
    do_alu(16'h0F0F, 4'd1, 1'b1, 1'b0);
    // load+store together is a store
    do_mem(1'b1, 1'b1, 16'h0022, 16'h1111, 4'd4, 1'b1, 1'b0, 1, 16'h2222);

    // 4: timeout sets sticky err, following ALU op is normal
    do_mem(1'b1, 1'b0, 16'h0300, 16'h0000, 4'd6, 1'b1, 1'b0, TO, 16'h0000);
    do_alu(16'h4321, 4'd8, 1'b1, 1'b0);
    idle_cycle(1'b0);
    chk("err_sticky", err, 1'b1);

    // 5: reset in the second request cycle abandons the access
    in_valid = 1'b1; in_ld = 1'b1; in_st = 1'b0; in_addr = 16'h0500; in_rd = 4'd9; in_we = 1'b1;
    step();
    in_valid = 1'b0; in_ld = 1'b0;
    step();
    chk("rstreq_mem_req_pre", mem_req, 1'b1);
    #2 rst_n = 1'b1;
    #1;
    chk("rstreq_mem_req", mem_req, 1'b0);
    chk("rstreq_out_valid", out_valid, 1'b0);
    chk("rstreq_err", err, 1'b0);
    model_err = 1'b0;
    #2 rst_n = 1'b0;
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("rstreq_no_valid", out_valid, 1'b0);
    chk("rstreq_in_ready", in_ready, 1'b1);
    idle_cycle(1'b0);

    // randomized traffic
    for (int t = 0; t < 60; t++) begin
      op = $urandom_range(0, 9);
      if (op < 4) begin
        do_alu(DW'($urandom), RW'($urandom), 1'($urandom), 1'b0);
      end else begin
        ld = 1'($urandom); st = 1'($urandom);
        if (!ld && !st) ld = 1'b1;
        lat = ($urandom_range(0, 9) == 0) ? TO + $urandom_range(0, 3) : $urandom_range(0, 4);
        do_mem(ld, st, AW'($urandom), DW'($urandom), RW'($urandom), 1'($urandom),
               1'b0, lat, DW'($urandom));
      end
      if ($urandom_range(0, 3) == 0) idle_cycle(1'($urandom));
    end

    // 6: halt is terminal
    do_alu(16'h00FF, 4'd15, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_ld = 1'($urandom); in_st = 1'b0; in_alu = DW'($urandom);
      mem_ack = 1'b1; mem_rdata = DW'($urandom);
      step();
      chk("halt_in_ready", in_ready, 1'b0);
      chk("halt_out_valid", out_valid, 1'b0);
      chk("halt_mem_req", mem_req, 1'b0);
    end
    in_valid = 1'b0; mem_ack = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Parametrised memory-access stage between EX and write-back in the pipelined CPU.
- Accepts one EX result per cycle and issues loads/stores to data memory over a req/ack handshake with variable latency.
- Stalls upstream while a memory access is outstanding, then delivers a registered write-back bundle.
- Generalises the fixed 16-bit datapath to DATA_W/ADDR_W and adds an access timeout with a sticky error flag.

Parameters:
DATA_W, 16, datapath and memory data width
ADDR_W, 16, data memory address width
REG_W, 4, destination register index width
TIMEOUT, 15, max cycles mem_req may wait for mem_ack (≥1)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous reset, active-high (asserted = 1)
in_valid  in  1  EX bundle valid this cycle
in_ready  out  1  stage can accept (0 = stall upstream)
in_ld  in  1  bundle is a load
in_st  in  1  bundle is a store
in_addr  in  ADDR_W  memory address (EX dst)
in_wdata  in  DATA_W  store data
in_alu  in  DATA_W  ALU result for non-memory ops
in_rd  in  REG_W  destination register
in_we  in  1  register write enable
in_hlt  in  1  halt marker
mem_req  out  1  memory request, held until ack
mem_wr  out  1  1 = write, 0 = read
mem_addr  out  ADDR_W  request address
mem_wdata  out  DATA_W  write data
mem_ack  in  1  request complete; mem_rdata valid same cycle for reads
mem_rdata  in  DATA_W  read data
out_valid  out  1  one-cycle pulse, WB bundle valid
out_data  out  DATA_W  write-back data
out_rd  out  REG_W  destination register
out_we  out  1  register write enable
out_hlt  out  1  halt marker to WB
err  out  1  sticky timeout flag

Behaviour:
- Reset (rst_n = 1, asynchronous): state IDLE; every output 0 except in_ready = 1 after release; timeout counter 0; err 0. Reset during REQ drops mem_req immediately and abandons the access; no out_valid follows.
- States: IDLE, REQ, HALT. in_ready = (state == IDLE).

IDLE, in_valid and neither ld nor st:
- Next cycle: out_valid = 1, out_data = in_alu, out_rd, out_we and out_hlt copied.
- Latency 1; throughput 1 per cycle.

IDLE, in_valid and (ld or st):
- Capture addr, wdata, rd, we and hlt.
- Next cycle: state REQ, mem_req = 1, mem_wr = in_st.
- If in_ld and in_st are both 1, the store takes priority.

REQ:
- mem_req, mem_wr, mem_addr and mem_wdata are held stable until ack.
- Counter increments each cycle without ack.
- On mem_ack: mem_req = 0 next cycle and out_valid pulses next cycle.
  - Load: out_data = mem_rdata (sampled in the ack cycle), out_we = captured we.
  - Store: out_data = 0, out_we = 0.
  - Return to IDLE.
- Ack in the first REQ cycle: accepted at T, out_valid at T+2, next accept at T+2.
- On timeout (counter reaches TIMEOUT without ack): err = 1 (sticky until reset), mem_req = 0, out_valid pulses with out_we = 0, return to IDLE.
- mem_ack arriving in IDLE or HALT is ignored.

Halt:
- When out_valid pulses with out_hlt = 1, state goes to HALT.
- In HALT: in_ready = 0, no further outputs, until reset.

General rules:
- out_valid is never asserted two consecutive cycles for a memory op; WB has no backpressure.
- in_valid while in_ready = 0 is ignored; upstream holds the bundle.
- Widths are exact with no extension; mem_addr = captured in_addr.

Test Plan:
1. Reset then ALU op: in_alu=0x1234, rd=3, we=1 -> next cycle out_valid=1, out_data=0x1234, out_rd=3, out_we=1; in_ready stays 1.
2. Load addr=0x0040, mem_ack 3 cycles after mem_req rises, rdata=0xBEEF -> mem_req held 3 cycles with mem_wr=0 and addr 0x0040; in_ready=0 throughout; then out_valid with out_data=0xBEEF, out_we=1.
3. Store addr=0x0010, wdata=0x00AA, zero-wait ack -> mem_wr=1, mem_wdata=0x00AA for one cycle; out_valid with out_we=0; next bundle accepted at T+2.
4. Load with no ack, TIMEOUT=15 -> mem_req drops after 15 cycles; err=1 and stays 1; out_valid with out_we=0; following ALU op completes normally.
5. Assert rst_n in the 2nd cycle of REQ -> mem_req=0 immediately; no out_valid; in_ready=1 after release.
6. ALU op with in_hlt=1 -> out_valid and out_hlt=1; in_ready=0 permanently; later in_valid and mem_ack have no effect.
